flag_selector: RTL and testbench

FLAG_SELECTOR -- requirements
Module: flag_selector

---
 rtl/vga_pride_pkg.sv | 42 ++++
 rtl/btn_debounce.sv | 55 +++++
 rtl/flag_selector.sv | 127 ++++++++++++
 tb/tb_flag_selector.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pride_pkg.sv
// vga_pride_pkg: shared widths, button map and index helpers
// for the pride-flag selector.
package vga_pride_pkg;

    localparam int FLAG_IDX_W      = 7;
    localparam int BTN_W           = 4;

    localparam int BTN_CLEAR       = 3;
    localparam int BTN_NEXT        = 2;
    localparam int BTN_PREV        = 1;
    localparam int BTN_LOAD        = 0;

    localparam int DEF_DB_BITS     = 18;
    localparam int DEF_AUTO_FRAMES = 300;

    typedef logic [FLAG_IDX_W-1:0] flag_idx_t;

    // Step forward, wrapping past lim back to 0.
    function automatic flag_idx_t idx_inc(
        input flag_idx_t cur,
        input flag_idx_t lim
    );
        return (cur < lim) ? cur + flag_idx_t'(1) : '0;
    endfunction

    // Step back, wrapping below 0 up to lim.
    function automatic flag_idx_t idx_dec(
        input flag_idx_t cur,
        input flag_idx_t lim
    );
        return (cur > '0) ? cur - flag_idx_t'(1) : lim;
    endfunction

    // Out-of-range loads fall back to the first flag.
    function automatic flag_idx_t idx_load(
        input flag_idx_t val,
        input flag_idx_t lim
    );
        return (val <= lim) ? val : '0;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, counter debouncer and
// one-cycle press event for a single raw button.
module btn_debounce #(
    parameter int DB_BITS = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic event_o
);

    logic               sync1_q;
    logic               sync2_q;
    logic               stable_q;
    logic               stable_d;
    logic               rise_q;
    logic               rise_d;
    logic [DB_BITS-1:0] cnt_q;
    logic [DB_BITS-1:0] cnt_d;

    // Count consecutive mismatches; flip the stable level on overflow.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (&cnt_q) begin
                stable_d = sync2_q;
                rise_d   = sync2_q;
            end else begin
                cnt_d = cnt_q + DB_BITS'(1);
            end
        end
    end

    // Synchronizer, debounce state and press-event register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign event_o = rise_q;

endmodule

// File: rtl/flag_selector.sv
// flag_selector: debounced buttons pick the flag index shown next frame.
// Define AUTO_CYCLE_EN to build the auto-advance frame counter.
module flag_selector
    import vga_pride_pkg::*;
#(
    parameter int DB_BITS     = DEF_DB_BITS,
    parameter int AUTO_FRAMES = DEF_AUTO_FRAMES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BTN_W-1:0]      btn,
    input  logic [FLAG_IDX_W-1:0] load_val,
    input  logic [FLAG_IDX_W-1:0] max_idx,
    input  logic                  frame_start,
    input  logic                  auto_en,
    output logic [FLAG_IDX_W-1:0] flag_idx,
    output logic                  changed
);

    logic [BTN_W-1:0] btn_ev;
    logic             auto_ev;
    flag_idx_t        next_idx_q;
    flag_idx_t        next_idx_d;
    flag_idx_t        flag_idx_q;
    flag_idx_t        flag_idx_d;
    logic             changed_q;
    logic             changed_d;

    for (genvar i = 0; i < BTN_W; i++) begin : g_db
        btn_debounce #(
            .DB_BITS (DB_BITS)
        ) u_db (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_i   (btn[i]),
            .event_o (btn_ev[i])
        );
    end

`ifdef AUTO_CYCLE_EN
    localparam int FC_W = $clog2(AUTO_FRAMES + 1);

    logic [FC_W-1:0] frm_cnt_q;
    logic [FC_W-1:0] frm_cnt_d;
    logic            auto_q;
    logic            auto_d;

    // Count frames while enabled; any button activity restarts the wait.
    always_comb begin
        frm_cnt_d = frm_cnt_q;
        auto_d    = 1'b0;
        if (!auto_en || (|btn_ev)) begin
            frm_cnt_d = '0;
        end else if (frame_start) begin
            if (frm_cnt_q == FC_W'(AUTO_FRAMES - 1)) begin
                frm_cnt_d = '0;
                auto_d    = 1'b1;
            end else begin
                frm_cnt_d = frm_cnt_q + FC_W'(1);
            end
        end
    end

    // Frame counter and auto-advance event register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt_q <= '0;
            auto_q    <= 1'b0;
        end else begin
            frm_cnt_q <= frm_cnt_d;
            auto_q    <= auto_d;
        end
    end

    assign auto_ev = auto_q;
`else
    logic unused_auto;

    assign unused_auto = auto_en ^ (AUTO_FRAMES == 0);
    assign auto_ev     = 1'b0;
`endif

    // Resolve this cycle's events into the pending index, highest priority first.
    always_comb begin
        next_idx_d = next_idx_q;
        if (btn_ev[BTN_CLEAR]) begin
            next_idx_d = '0;
        end else if (btn_ev[BTN_NEXT]) begin
            next_idx_d = idx_inc(next_idx_q, max_idx);
        end else if (btn_ev[BTN_PREV]) begin
            next_idx_d = idx_dec(next_idx_q, max_idx);
        end else if (btn_ev[BTN_LOAD]) begin
            next_idx_d = idx_load(load_val, max_idx);
        end else if (auto_ev) begin
            next_idx_d = idx_inc(next_idx_q, max_idx);
        end else if (next_idx_q > max_idx) begin
            next_idx_d = '0;
        end
    end

    // Present the pending index only at frame start so a frame never tears.
    always_comb begin
        flag_idx_d = flag_idx_q;
        changed_d  = 1'b0;
        if (frame_start) begin
            flag_idx_d = next_idx_q;
            changed_d  = (next_idx_q != flag_idx_q);
        end
    end

    // Pending index, displayed index and change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_idx_q <= '0;
            flag_idx_q <= '0;
            changed_q  <= 1'b0;
        end else begin
            next_idx_q <= next_idx_d;
            flag_idx_q <= flag_idx_d;
            changed_q  <= changed_d;
        end
    end

    assign flag_idx = flag_idx_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_flag_selector.sv
// tb_flag_selector: scoreboard bench for flag_selector (DB_BITS=4,
// AUTO_FRAMES=3); covers AUTO_CYCLE_EN both defined and undefined.
module tb_flag_selector;

    localparam int DBB = 4;
    localparam int AF  = 3;

    localparam logic [3:0] B_CLEAR = 4'b1000;
    localparam logic [3:0] B_NEXT  = 4'b0100;
    localparam logic [3:0] B_PREV  = 4'b0010;
    localparam logic [3:0] B_LOAD  = 4'b0001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn = '0;
    logic [6:0] load_val = '0;
    logic [6:0] max_idx = 7'd5;
    logic       frame_start = 1'b0;
    logic       auto_en = 1'b0;
    logic [6:0] flag_idx;
    logic       changed;

    typedef struct {
        logic [6:0] idx;
        logic       chg;
    } exp_t;

    exp_t       sb[$];
    exp_t       sb_e;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [6:0] m_next = '0;
    logic [6:0] m_shown = '0;

    flag_selector #(
        .DB_BITS     (DBB),
        .AUTO_FRAMES (AF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .load_val    (load_val),
        .max_idx     (max_idx),
        .frame_start (frame_start),
        .auto_en     (auto_en),
        .flag_idx    (flag_idx),
        .changed     (changed)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] bits, input int hold);
        btn = bits;
        repeat (hold) tick();
        btn = '0;
        repeat (25) tick();
    endtask

    task automatic frame();
        sb.push_back('{m_next, (m_next != m_shown)});
        m_shown = m_next;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (6) tick();
    endtask

    // Scoreboard consumer: each frame_start edge produces one output.
    always @(posedge clk) begin
        if (frame_start) begin
            #1;
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: flag_idx=%0d with no expected entry", flag_idx);
            end else begin
                sb_e = sb.pop_front();
                if (flag_idx !== sb_e.idx) begin
                    n_fail++;
                    $display("FAIL frame_idx: got %0d want %0d", flag_idx, sb_e.idx);
                end
                n_chk++;
                if (changed !== sb_e.chg) begin
                    n_fail++;
                    $display("FAIL frame_changed: got %0b want %0b", changed, sb_e.chg);
                end
            end
            @(posedge clk);
            #1;
            n_chk++;
            if (changed !== 1'b0) begin
                n_fail++;
                $display("FAIL changed_width: got %0b want 0", changed);
            end
        end
    end

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) tick();
        n_chk++;
        if (flag_idx !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flag: got %0d want 0", flag_idx);
        end
        n_chk++;
        if (changed !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_changed: got %0b want 0", changed);
        end
        n_chk++;
        if (dut.next_idx_q !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_next: got %0d want 0", dut.next_idx_q);
        end
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_sequence();
        logic [6:0] want;
        max_idx = 7'd5;
        for (int i = 0; i < 6; i++) begin
            press(B_NEXT, 20);
            want = 7'((i + 1) % 6);
            n_chk++;
            if (dut.next_idx_q !== want) begin
                n_fail++;
                $display("FAIL seq_next%0d: got %0d want %0d", i, dut.next_idx_q, want);
            end
            m_next = want;
            frame();
        end
    endtask

    task automatic test_glitch();
        press(B_NEXT, 10);
        n_chk++;
        if (dut.next_idx_q !== 7'd0) begin
            n_fail++;
            $display("FAIL glitch_ignored: got %0d want 0", dut.next_idx_q);
        end
        press(B_NEXT, 30);
        n_chk++;
        if (dut.next_idx_q !== 7'd1) begin
            n_fail++;
            $display("FAIL glitch_press: got %0d want 1", dut.next_idx_q);
        end
        m_next = 7'd1;
        frame();
    endtask

    task automatic test_prev_load();
        press(B_CLEAR, 20);
        n_chk++;
        if (dut.next_idx_q !== 7'd0) begin
            n_fail++;
            $display("FAIL clear: got %0d want 0", dut.next_idx_q);
        end
        press(B_PREV, 20);
        n_chk++;
        if (dut.next_idx_q !== 7'd5) begin
            n_fail++;
            $display("FAIL prev_wrap: got %0d want 5", dut.next_idx_q);
        end
        load_val = 7'd9;
        press(B_LOAD, 20);
        n_chk++;
        if (dut.next_idx_q !== 7'd0) begin
            n_fail++;
            $display("FAIL load_oob: got %0d want 0", dut.next_idx_q);
        end
        load_val = 7'd3;
        press(B_LOAD, 20);
        n_chk++;
        if (dut.next_idx_q !== 7'd3) begin
            n_fail++;
            $display("FAIL load_ok: got %0d want 3", dut.next_idx_q);
        end
        m_next = 7'd3;
        frame();
    endtask

    task automatic test_clear_next();
        press(B_CLEAR | B_NEXT, 20);
        n_chk++;
        if (dut.next_idx_q !== 7'd0) begin
            n_fail++;
            $display("FAIL clear_prio: got %0d want 0", dut.next_idx_q);
        end
        m_next = 7'd0;
        frame();
        frame();
    endtask

    task automatic test_shrink();
        load_val = 7'd4;
        press(B_LOAD, 20);
        m_next = 7'd4;
        frame();
        max_idx = 7'd2;
        tick();
        n_chk++;
        if (dut.next_idx_q !== 7'd0) begin
            n_fail++;
            $display("FAIL shrink: got %0d want 0", dut.next_idx_q);
        end
        m_next = 7'd0;
        frame();
        max_idx = 7'd5;
    endtask

    task automatic test_reset_mid();
        load_val = 7'd2;
        press(B_LOAD, 20);
        m_next = 7'd2;
        frame();
        btn = B_NEXT;
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (flag_idx !== 7'd0 || changed !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst: flag=%0d chg=%0b want 0 0", flag_idx, changed);
        end
        n_chk++;
        if (dut.next_idx_q !== 7'd0) begin
            n_fail++;
            $display("FAIL async_rst_next: got %0d want 0", dut.next_idx_q);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        m_next = 7'd0;
        m_shown = 7'd0;
        press(B_NEXT, 25);
        n_chk++;
        if (dut.next_idx_q !== 7'd1) begin
            n_fail++;
            $display("FAIL held_thru_rst: got %0d want 1", dut.next_idx_q);
        end
        m_next = 7'd1;
        frame();
    endtask

    task automatic test_auto();
        int cnt;
        cnt = 0;
        auto_en = 1'b1;
        tick();
`ifdef AUTO_CYCLE_EN
        for (int f = 0; f < 8; f++) begin
            frame();
            cnt++;
            if (cnt == AF) begin
                m_next = m_next + 7'd1;
                cnt = 0;
            end
            if (f == 3) begin
                press(B_NEXT, 20);
                m_next = m_next + 7'd1;
                cnt = 0;
            end
        end
`else
        for (int f = 0; f < 4; f++) begin
            frame();
        end
`endif
        n_chk++;
        if (dut.next_idx_q !== m_next) begin
            n_fail++;
            $display("FAIL auto_next: got %0d want %0d", dut.next_idx_q, m_next);
        end
        auto_en = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequence();
        test_glitch();
        test_prev_load();
        test_clear_next();
        test_shrink();
        test_reset_mid();
        test_auto();
        repeat (5) tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_left: %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
